// File: rtl/spike_vote_fc.sv
// spike_vote_fc: per-neuron spike counting over T_STEPS valid timesteps,
// followed by a one-neuron-per-cycle argmax that yields the winning class.
module spike_vote_fc #(
  parameter int N_OUT   = 10,
  parameter int T_STEPS = 8,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     spk_valid,
  input  logic [N_OUT-1:0]         spk_in,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(N_OUT)-1:0] class_out,
  output logic [CNT_W-1:0]         class_cnt,
  output logic [N_OUT*CNT_W-1:0]   cnt_bus
);

  localparam int CW = $clog2(N_OUT);
  localparam int IW = $clog2(N_OUT + 1);   // idx also encodes the final "load result" cycle
  localparam int SW = $clog2(T_STEPS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_ARGMAX} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     step_q, step_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     best_idx_q, best_idx_d;
  logic [CNT_W-1:0]  best_cnt_q, best_cnt_d;
  logic [CNT_W-1:0]  cnt_q [N_OUT];
  logic [CNT_W-1:0]  cnt_d [N_OUT];
  logic [CW-1:0]     class_q, class_d;
  logic [CNT_W-1:0]  class_cnt_q, class_cnt_d;
  logic              done_q, done_d;

  // Next-state: counter accumulation, sequential argmax, result load
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    idx_d       = idx_q;
    best_idx_d  = best_idx_q;
    best_cnt_d  = best_cnt_q;
    cnt_d       = cnt_q;
    class_d     = class_q;
    class_cnt_d = class_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int i = 0; i < N_OUT; i++) cnt_d[i] = '0;
          step_d  = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (spk_valid) begin
          for (int i = 0; i < N_OUT; i++)
            if (spk_in[i] && cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_W'(1);
          step_d = step_q + SW'(1);
          if (step_q == SW'(T_STEPS - 1)) begin
            state_d    = S_ARGMAX;
            idx_d      = '0;
            best_idx_d = '0;
            best_cnt_d = '0;
          end
        end
      end
      S_ARGMAX: begin
        // idx == N_OUT is the extra cycle that publishes the result
        if (idx_q == IW'(N_OUT)) begin
          class_d     = best_idx_q;
          class_cnt_d = best_cnt_q;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end else begin
          // strict compare keeps the lowest index on ties
          if (cnt_q[idx_q[CW-1:0]] > best_cnt_q) begin
            best_idx_d = idx_q[CW-1:0];
            best_cnt_d = cnt_q[idx_q[CW-1:0]];
          end
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      idx_q       <= '0;
      best_idx_q  <= '0;
      best_cnt_q  <= '0;
      class_q     <= '0;
      class_cnt_q <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      idx_q       <= idx_d;
      best_idx_q  <= best_idx_d;
      best_cnt_q  <= best_cnt_d;
      class_q     <= class_d;
      class_cnt_q <= class_cnt_d;
      done_q      <= done_d;
      for (int i = 0; i < N_OUT; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_bus
    assign cnt_bus[CNT_W*g +: CNT_W] = cnt_q[g];
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign class_out = class_q;
  assign class_cnt = class_cnt_q;

endmodule

// File: tb/tb_spike_vote_fc.sv
// Directed bench for spike_vote_fc: default instance (A) and a narrow-counter
// instance (B: CNT_W=3, T_STEPS=10) for saturation.
module tb_spike_vote_fc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic st_a, v_a, busy_a, done_a;
  logic [9:0] in_a;
  logic [3:0] cls_a;
  logic [7:0] cc_a;
  logic [79:0] bus_a;
  logic st_b, v_b, busy_b, done_b;
  logic [9:0] in_b;
  logic [3:0] cls_b;
  logic [2:0] cc_b;
  logic [29:0] bus_b;

  spike_vote_fc u_a (
    .clk(clk), .rst(rst), .start(st_a), .spk_valid(v_a), .spk_in(in_a),
    .busy(busy_a), .done(done_a), .class_out(cls_a), .class_cnt(cc_a), .cnt_bus(bus_a));

  spike_vote_fc #(.N_OUT(10), .T_STEPS(10), .CNT_W(3)) u_b (
    .clk(clk), .rst(rst), .start(st_b), .spk_valid(v_b), .spk_in(in_b),
    .busy(busy_b), .done(done_b), .class_out(cls_b), .class_cnt(cc_b), .cnt_bus(bus_b));

  int n_chk = 0, n_err = 0;
  int ndone_a = 0, ndone_b = 0;
  logic [9:0] pat [16];
  int ecnt [10];

  always @(negedge clk) begin
    if (done_a) ndone_a++;
    if (done_b) ndone_b++;
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] ebus(input bit sel);
    logic [79:0] e = '0;
    for (int i = 0; i < 10; i++)
      if (sel) e[3*i +: 3] = ecnt[i][2:0];
      else     e[8*i +: 8] = ecnt[i][7:0];
    return e;
  endfunction

  function automatic logic [79:0] gbus(input bit sel);
    return sel ? {50'b0, bus_b} : bus_a;
  endfunction

  function automatic logic gbusy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  task automatic drv(input bit sel, input logic s, input logic v, input logic [9:0] d);
    if (sel) begin st_b = s; v_b = v; in_b = d; end
    else     begin st_a = s; v_a = v; in_a = d; end
  endtask

  // called at a negedge; returns at the negedge after start was accepted
  task automatic do_start(input bit sel);
    drv(sel, 1'b1, 1'b0, '0);
    @(negedge clk);
    drv(sel, 1'b0, 1'b0, '0);
    for (int i = 0; i < 10; i++) ecnt[i] = 0;
    check("busy_after_start", {79'b0, gbusy(sel)}, 80'd1);
  endtask

  // feed n valids from pat[]; optional random gaps and a stray start at step xs
  task automatic feed(input bit sel, input int n, input bit gaps, input int xs);
    int mx = sel ? 7 : 255;
    for (int s = 0; s < n; s++) begin
      if (gaps) begin
        int g = $urandom_range(0, 3);
        for (int k = 0; k < g; k++) begin drv(sel, 1'b0, 1'b0, 10'h3ff); @(negedge clk); end
      end
      if (s == xs) begin drv(sel, 1'b1, 1'b0, '0); @(negedge clk); end
      drv(sel, 1'b0, 1'b1, pat[s]);
      @(negedge clk);
      for (int i = 0; i < 10; i++) if (pat[s][i] && ecnt[i] < mx) ecnt[i]++;
      if (s == 0 || s == n - 1) check("cnt_bus_step", gbus(sel), ebus(sel));
    end
    drv(sel, 1'b0, 1'b0, '0);
  endtask

  // count negedges until done; optionally assert start in the done cycle
  task automatic wait_done(input bit sel, input bit chain, output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if ((sel ? done_b : done_a) === 1'b1) begin lat = k; break; end
    end
    check("busy_falls_with_done", {79'b0, gbusy(sel)}, 80'd0);
    if (chain) drv(sel, 1'b1, 1'b0, '0);
    @(negedge clk);
    drv(sel, 1'b0, 1'b0, '0);
    check("done_one_cycle", {79'b0, sel ? done_b : done_a}, 80'd0);
  endtask

  initial begin
    int lat, nd0;
    rst = 1'b1;
    drv(0, 0, 0, '0); drv(1, 0, 0, '0);
    repeat (2) @(negedge clk);
    check("rst_busy", {79'b0, busy_a}, 80'd0);
    check("rst_done", {79'b0, done_a}, 80'd0);
    check("rst_class", {76'b0, cls_a}, 80'd0);
    check("rst_ccnt", {72'b0, cc_a}, 80'd0);
    check("rst_bus", bus_a, 80'd0);
    rst = 1'b0;
    @(negedge clk);

    // single winner: neuron 3 on all 8 steps
    for (int s = 0; s < 8; s++) pat[s] = 10'b0000001000;
    nd0 = ndone_a;
    do_start(0);
    feed(0, 8, 0, -1);
    wait_done(0, 0, lat);
    check("single_latency", 80'(lat), 80'd11);
    check("single_class", {76'b0, cls_a}, 80'd3);
    check("single_ccnt", {72'b0, cc_a}, 80'd8);
    check("single_bus", bus_a, 80'h08 << 24);
    check("single_ndone", 80'(ndone_a - nd0), 80'd1);

    // reset mid-ACCUM after 3 valids: everything cleared, no done
    for (int s = 0; s < 8; s++) pat[s] = 10'b0000010000;
    do_start(0);
    feed(0, 3, 0, -1);
    nd0 = ndone_a;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {79'b0, busy_a}, 80'd0);
    check("midrst_class", {76'b0, cls_a}, 80'd0);
    check("midrst_ccnt", {72'b0, cc_a}, 80'd0);
    check("midrst_bus", bus_a, 80'd0);
    repeat (15) @(negedge clk);
    check("midrst_no_done", 80'(ndone_a - nd0), 80'd0);
    check("midrst_idle", {79'b0, busy_a}, 80'd0);

    // tie: neurons 2 and 7 four times each, neuron 5 three times
    pat[0] = 10'b0000100100; pat[1] = 10'b0000000100;
    pat[2] = 10'b0000100100; pat[3] = 10'b0000000100;
    pat[4] = 10'b0010100000; pat[5] = 10'b0010000000;
    pat[6] = 10'b0010000000; pat[7] = 10'b0010000000;
    do_start(0);
    feed(0, 8, 0, -1);
    wait_done(0, 0, lat);
    check("tie_latency", 80'(lat), 80'd11);
    check("tie_class", {76'b0, cls_a}, 80'd2);
    check("tie_ccnt", {72'b0, cc_a}, 80'd4);
    check("tie_bus", bus_a, (80'd4 << 56) | (80'd3 << 40) | (80'd4 << 16));

    // silence with random gaps and a stray start during ACCUM
    for (int s = 0; s < 8; s++) pat[s] = '0;
    nd0 = ndone_a;
    do_start(0);
    feed(0, 8, 1, 4);
    wait_done(0, 0, lat);
    check("silence_latency", 80'(lat), 80'd11);
    check("silence_class", {76'b0, cls_a}, 80'd0);
    check("silence_ccnt", {72'b0, cc_a}, 80'd0);
    repeat (15) @(negedge clk);
    check("silence_ndone", 80'(ndone_a - nd0), 80'd1);

    // back-to-back: neuron 6 sample, start in the done cycle, then neuron 1
    for (int s = 0; s < 8; s++) pat[s] = 10'b0001000000;
    do_start(0);
    feed(0, 8, 0, -1);
    wait_done(0, 1, lat);
    check("b2b_first_class", {76'b0, cls_a}, 80'd6);
    check("b2b_busy", {79'b0, busy_a}, 80'd1);
    check("b2b_bus_cleared", bus_a, 80'd0);
    for (int i = 0; i < 10; i++) ecnt[i] = 0;
    for (int s = 0; s < 8; s++) pat[s] = 10'b0000000010;
    feed(0, 8, 0, -1);
    wait_done(0, 0, lat);
    check("b2b_latency", 80'(lat), 80'd11);
    check("b2b_class", {76'b0, cls_a}, 80'd1);
    check("b2b_ccnt", {72'b0, cc_a}, 80'd8);

    // saturation on the 3-bit instance: neuron 9 x10, neuron 0 x6
    for (int s = 0; s < 10; s++) pat[s] = (s < 6) ? 10'b1000000001 : 10'b1000000000;
    do_start(1);
    feed(1, 10, 0, -1);
    wait_done(1, 0, lat);
    check("sat_latency", 80'(lat), 80'd11);
    check("sat_class", {76'b0, cls_b}, 80'd9);
    check("sat_ccnt", {77'b0, cc_b}, 80'd7);
    check("sat_bus", {50'b0, bus_b}, (80'd7 << 27) | 80'd6);
    check("sat_ndone", 80'(ndone_b), 80'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
